// File: rtl/pipeline_stall_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_sequencer_if
// Groups the hazard inputs and the pipeline control outputs of the stall
// sequencer into a single bundle. clk and reset stay plain ports on the module.
//
// Signals (direction as seen by the sequencer, modport slave):
//   ID_EX_MemRead            in   EX instruction is a load
//   ID_EX_RD                 in   destination register of the EX instruction
//   IF_ID_RS1, IF_ID_RS2     in   source registers of the ID instruction
//   Branch_Taken             in   EX resolved a taken branch/jump
//   Dmem_Req, Dmem_Ready     in   MEM stage access request / completion
//   Halt_Req, Resume         in   halt the fetch stream / release the halt
//   PCWrite, IF_ID_Write     out  PC and IF/ID update enables
//   Pipe_Write               out  ID/EX, EX/MEM, MEM/WB update enable
//   IF_ID_Flush              out  flush the IF/ID register
//   ID_EX_Control_Mux_Out    out  ID/EX control select, 0 inserts a bubble
//   Mem_Err                  out  one-cycle pulse on memory wait timeout
//   Halted                   out  high while halted
//   Stall_Count              out  saturating count of PCWrite=0 cycles
// -----------------------------------------------------------------------------
interface pipeline_stall_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RD;
   logic [4:0]       IF_ID_RS1;
   logic [4:0]       IF_ID_RS2;
   logic             Branch_Taken;
   logic             Dmem_Req;
   logic             Dmem_Ready;
   logic             Halt_Req;
   logic             Resume;
   logic             PCWrite;
   logic             IF_ID_Write;
   logic             Pipe_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Control_Mux_Out;
   logic             Mem_Err;
   logic             Halted;
   logic [CNT_W-1:0] Stall_Count;

   // The pipeline side drives the hazard information and consumes the enables.
   modport master (
      output ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2, Branch_Taken,
             Dmem_Req, Dmem_Ready, Halt_Req, Resume,
      input  PCWrite, IF_ID_Write, Pipe_Write, IF_ID_Flush,
             ID_EX_Control_Mux_Out, Mem_Err, Halted, Stall_Count
   );

   // The sequencer consumes the hazard information and drives the enables.
   modport slave (
      input  ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2, Branch_Taken,
             Dmem_Req, Dmem_Ready, Halt_Req, Resume,
      output PCWrite, IF_ID_Write, Pipe_Write, IF_ID_Flush,
             ID_EX_Control_Mux_Out, Mem_Err, Halted, Stall_Count
   );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_stall_sequencer
// Central stall/flush controller for a 5-stage pipeline. Resolves data memory
// waits (with timeout), taken-branch flushes, load-use bubbles and halt/resume,
// and counts the cycles in which the PC is held.
//
// Parameters:
//   WAIT_TIMEOUT  maximum consecutive memory wait cycles before abort
//   CNT_W         width of the stall cycle counter
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    pipeline_stall_sequencer_if.slave, hazard inputs and control outputs
// -----------------------------------------------------------------------------
module pipeline_stall_sequencer #(
   parameter int WAIT_TIMEOUT = 8,
   parameter int CNT_W        = 16
) (
   input logic                      clk,
   input logic                      reset,
   pipeline_stall_sequencer_if.slave bus
);

   localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TIMEOUT_VAL = WC_W'(WAIT_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_count_q;

   logic pc_write, ifid_write, pipe_write, ifid_flush, ctrl_sel, mem_err, halted;
   logic mem_stall, load_use;

   // Hazard decode. A load into x0 never creates a dependency.
   assign mem_stall = bus.Dmem_Req && !bus.Dmem_Ready;
   assign load_use  = bus.ID_EX_MemRead && (bus.ID_EX_RD != 5'd0) &&
                      ((bus.ID_EX_RD == bus.IF_ID_RS1) || (bus.ID_EX_RD == bus.IF_ID_RS2));

   // Next-state and control decode. Outputs are combinational so a stall
   // applies in the very cycle it is detected. While reset is held low the
   // free-running defaults stand, regardless of the hazard inputs.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      pipe_write = 1'b1;
      ifid_flush = 1'b0;
      ctrl_sel   = 1'b1;
      mem_err    = 1'b0;
      halted     = 1'b0;
      if (reset) begin
         case (state_q)
            RUN: begin
               wait_cnt_d = '0;
               if (mem_stall) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  pipe_write = 1'b0;
                  state_d    = MEM_WAIT;
                  wait_cnt_d = WC_W'(1);
               end else if (bus.Branch_Taken) begin
                  ifid_flush = 1'b1;
                  ctrl_sel   = 1'b0;
               end else if (load_use) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  ctrl_sel   = 1'b0;
               end else if (bus.Halt_Req) begin
                  state_d = HALT;
               end
            end
            MEM_WAIT: begin
               if (bus.Dmem_Ready) begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q >= TIMEOUT_VAL) begin
                  mem_err    = 1'b1;
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  pipe_write = 1'b0;
                  wait_cnt_d = wait_cnt_q + WC_W'(1);
               end
            end
            HALT: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               ctrl_sel   = 1'b0;
               halted     = 1'b1;
               if (bus.Resume) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         endcase
      end
   end

   // State, wait counter and the saturating stall counter. The stall counter
   // advances on every edge where the PC was held and sticks at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         stall_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!pc_write && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
         end
      end
   end

   assign bus.PCWrite               = pc_write;
   assign bus.IF_ID_Write           = ifid_write;
   assign bus.Pipe_Write            = pipe_write;
   assign bus.IF_ID_Flush           = ifid_flush;
   assign bus.ID_EX_Control_Mux_Out = ctrl_sel;
   assign bus.Mem_Err               = mem_err;
   assign bus.Halted                = halted;
   assign bus.Stall_Count           = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_sequencer
// Self-checking bench for pipeline_stall_sequencer. Directed scenarios with
// hand-computed expectations, followed by randomized traffic compared every
// cycle against a behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_sequencer;

   localparam int TIMEOUT = 8;
   localparam int CW      = 4;
   localparam int CMAX    = (1 << CW) - 1;

   // Expected control vector:
   // {PCWrite, IF_ID_Write, Pipe_Write, IF_ID_Flush, Ctrl_Mux, Mem_Err, Halted}
   localparam logic [6:0] GO     = 7'b1110100;
   localparam logic [6:0] FREEZE = 7'b0000100;
   localparam logic [6:0] FLUSH  = 7'b1111000;
   localparam logic [6:0] BUBBLE = 7'b0010000;
   localparam logic [6:0] HALTO  = 7'b0010001;
   localparam logic [6:0] ERRB   = 7'b0000010;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_bad    = 0;

   pipeline_stall_sequencer_if #(.CNT_W(CW)) bus ();

   pipeline_stall_sequencer #(
      .WAIT_TIMEOUT (TIMEOUT),
      .CNT_W        (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic comparison: counts every check, reports mismatches.
   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle's worth of hazard inputs.
   task automatic applyStimulus(input bit mem_read, input int rd, input int rs1, input int rs2,
                                input bit br, input bit req, input bit rdy,
                                input bit halt, input bit resume);
      bus.ID_EX_MemRead = mem_read;
      bus.ID_EX_RD      = 5'(rd);
      bus.IF_ID_RS1     = 5'(rs1);
      bus.IF_ID_RS2     = 5'(rs2);
      bus.Branch_Taken  = br;
      bus.Dmem_Req      = req;
      bus.Dmem_Ready    = rdy;
      bus.Halt_Req      = halt;
      bus.Resume        = resume;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      nextCycle();
      reset = 1'b0;
      idle();
      nextCycle();
      reset = 1'b1;
   endtask

   // Behavioural model: how long a memory access has been pending (0 = none),
   // whether fetch is halted, and the expected stall tally.
   int m_wait_len = 0;
   bit m_halted   = 1'b0;
   int m_cnt      = 0;

   // Compare process: at every falling edge the inputs are stable, so the
   // combinational outputs are checked against the model, then the model
   // advances as the DUT will on the coming rising edge.
   always @(negedge clk) begin : compare_proc
      logic [6:0] exp_v;
      logic [6:0] act_v;
      bit         mem_stall;
      bit         hazard;
      act_v = {bus.PCWrite, bus.IF_ID_Write, bus.Pipe_Write, bus.IF_ID_Flush,
               bus.ID_EX_Control_Mux_Out, bus.Mem_Err, bus.Halted};
      if (!reset) begin
         m_wait_len = 0;
         m_halted   = 1'b0;
         m_cnt      = 0;
         exp_v      = GO;
         checkOutput("ctl_in_reset", int'(act_v), int'(exp_v));
         checkOutput("count_in_reset", int'(bus.Stall_Count), 0);
      end else begin
         mem_stall = bus.Dmem_Req && !bus.Dmem_Ready;
         hazard    = bus.ID_EX_MemRead && (bus.ID_EX_RD != 0) &&
                     ((bus.ID_EX_RD == bus.IF_ID_RS1) || (bus.ID_EX_RD == bus.IF_ID_RS2));
         if (m_wait_len > 0) begin
            if (bus.Dmem_Ready) begin
               exp_v = GO;
               m_wait_len = 0;
            end else if (m_wait_len == TIMEOUT) begin
               exp_v = GO | ERRB;
               m_wait_len = 0;
            end else begin
               exp_v = FREEZE;
               m_wait_len++;
            end
         end else if (m_halted) begin
            exp_v = HALTO;
            if (bus.Resume) m_halted = 1'b0;
         end else if (mem_stall) begin
            exp_v = FREEZE;
            m_wait_len = 1;
         end else if (bus.Branch_Taken) begin
            exp_v = FLUSH;
         end else if (hazard) begin
            exp_v = BUBBLE;
         end else begin
            exp_v = GO;
            if (bus.Halt_Req) m_halted = 1'b1;
         end
         checkOutput("ctl_vector", int'(act_v), int'(exp_v));
         checkOutput("stall_count", int'(bus.Stall_Count), m_cnt);
         if (!exp_v[6] && m_cnt < CMAX) m_cnt++;
      end
   end

   int err_pulses;
   int err_index;

   initial begin
      reset = 1'b0;
      idle();
      #2;
      // Reset state: free-running values and a cleared counter.
      checkOutput("reset_pcwrite", int'(bus.PCWrite), 1);
      checkOutput("reset_pipe_write", int'(bus.Pipe_Write), 1);
      checkOutput("reset_ctrl_mux", int'(bus.ID_EX_Control_Mux_Out), 1);
      checkOutput("reset_count", int'(bus.Stall_Count), 0);

      // Load-use on RS2 costs exactly one bubble; a load into x0 never stalls.
      doReset();
      nextCycle();
      applyStimulus(1, 5, 0, 5, 0, 0, 0, 0, 0);
      #2;
      checkOutput("lu_pcwrite", int'(bus.PCWrite), 0);
      checkOutput("lu_ifid_write", int'(bus.IF_ID_Write), 0);
      checkOutput("lu_ctrl_mux", int'(bus.ID_EX_Control_Mux_Out), 0);
      checkOutput("lu_pipe_write", int'(bus.Pipe_Write), 1);
      nextCycle();
      idle();
      #2;
      checkOutput("lu_count", int'(bus.Stall_Count), 1);
      checkOutput("lu_one_bubble", int'(bus.PCWrite), 1);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("x0_no_stall", int'(bus.PCWrite), 1);

      // Memory wait of three cycles, ready on the fourth.
      doReset();
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         applyStimulus(0, 0, 0, 0, 0, 1, (i == 3), 0, 0);
         #2;
         checkOutput($sformatf("mw_pipe_write_%0d", i), int'(bus.Pipe_Write), (i == 3) ? 1 : 0);
      end
      nextCycle();
      idle();
      #2;
      checkOutput("mw_back_in_run", int'(bus.PCWrite), 1);
      checkOutput("mw_count", int'(bus.Stall_Count), 3);

      // Timeout: ready never arrives, error pulses once on the ninth cycle.
      doReset();
      err_pulses = 0;
      err_index  = -1;
      for (int i = 0; i < 12; i++) begin
         nextCycle();
         applyStimulus(0, 0, 0, 0, 0, (i < 9), 0, 0, 0);
         #2;
         if (bus.Mem_Err) begin
            err_pulses++;
            err_index = i;
         end
      end
      checkOutput("to_err_pulses", err_pulses, 1);
      checkOutput("to_err_index", err_index, 8);
      checkOutput("to_back_in_run", int'(bus.PCWrite), 1);
      checkOutput("to_count", int'(bus.Stall_Count), 8);

      // Branch beats load-use; memory freeze beats branch.
      doReset();
      nextCycle();
      applyStimulus(1, 3, 3, 0, 1, 0, 0, 0, 0);
      #2;
      checkOutput("br_flush", int'(bus.IF_ID_Flush), 1);
      checkOutput("br_pcwrite", int'(bus.PCWrite), 1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0);
      #2;
      checkOutput("frz_no_flush", int'(bus.IF_ID_Flush), 0);
      checkOutput("frz_pcwrite", int'(bus.PCWrite), 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);

      // Halt (with simultaneous resume), long halt saturates the counter.
      doReset();
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2;
      checkOutput("halt_req_cycle_pcwrite", int'(bus.PCWrite), 1);
      checkOutput("halt_req_cycle_halted", int'(bus.Halted), 0);
      for (int i = 0; i < 20; i++) begin
         nextCycle();
         idle();
      end
      #2;
      checkOutput("halt_halted", int'(bus.Halted), 1);
      checkOutput("halt_pcwrite", int'(bus.PCWrite), 0);
      checkOutput("halt_saturated", int'(bus.Stall_Count), CMAX);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2;
      checkOutput("resume_cycle_halted", int'(bus.Halted), 1);
      nextCycle();
      idle();
      #2;
      checkOutput("resumed_halted", int'(bus.Halted), 0);
      checkOutput("resumed_pcwrite", int'(bus.PCWrite), 1);
      checkOutput("resumed_count_held", int'(bus.Stall_Count), CMAX);

      // Reset in the middle of a memory wait acts without a clock edge.
      doReset();
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      nextCycle();
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rst_mw_pcwrite", int'(bus.PCWrite), 1);
      checkOutput("rst_mw_pipe_write", int'(bus.Pipe_Write), 1);
      checkOutput("rst_mw_mem_err", int'(bus.Mem_Err), 0);
      checkOutput("rst_mw_count", int'(bus.Stall_Count), 0);
      nextCycle();
      idle();
      reset = 1'b1;

      // Randomized traffic; the compare process checks every cycle.
      for (int blk = 0; blk < 60; blk++) begin
         int rdy_pct;
         rdy_pct = ($urandom_range(0, 3) == 0) ? 5 : 60;
         for (int i = 0; i < 50; i++) begin
            nextCycle();
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            applyStimulus(($urandom_range(0, 99) < 40),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)),
                          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < rdy_pct),
                          ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20));
         end
      end
      nextCycle();
      reset = 1'b1;
      idle();
      nextCycle();
      nextCycle();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
